// File: rtl/float_add_issue_pkg.sv
// Shared float parameters for the add issue stage: operand width and the
// quiet-NaN value returned when an op has to be abandoned.
package float_add_issue_pkg;

  localparam int FLOAT_WIDTH = 32;
  localparam logic [FLOAT_WIDTH-1:0] FLOAT_QNAN = 32'h7fc00000;

endpackage

// File: rtl/float_req_fifo.sv
// Synchronous request FIFO with occupancy count; the head entry is visible
// combinationally on rd_data. A push while full is refused even if a pop happens in the same cycle.
module float_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("float_req_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Pointers wrap naturally at DEPTH; count alone distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/float_add_issue.sv
// Issue stage in front of float_add_pipeline: queues tagged add requests and runs them
// one at a time. Optional WAIT watchdog enabled by defining FLOAT_ADD_ISSUE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// ISSUE | add_req high for this single cycle
// WAIT  | operands held, waiting for add_ack (or watchdog expiry)
// RESP  | result presented on res_*, waiting for res_ready
module float_add_issue
  import float_add_issue_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_WIDTH-1:0]     in_a,
  input  logic [FLOAT_WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       add_req,
  output logic [FLOAT_WIDTH-1:0]     add_a,
  output logic [FLOAT_WIDTH-1:0]     add_b,
  input  logic                       add_ack,
  input  logic [FLOAT_WIDTH-1:0]     add_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [FLOAT_WIDTH-1:0]     res_out,
  output logic [TAG_WIDTH-1:0]       res_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       timeout_err
);

  localparam int EW = 2*FLOAT_WIDTH + TAG_WIDTH;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("float_add_issue: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [EW-1:0]          fifo_wr;
  logic [EW-1:0]          fifo_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [FLOAT_WIDTH-1:0] head_a;
  logic [FLOAT_WIDTH-1:0] head_b;
  logic [TAG_WIDTH-1:0]   head_tag;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_wr   = {in_a, in_b, in_tag};
  assign head_a    = fifo_rd[EW-1 -: FLOAT_WIDTH];
  assign head_b    = fifo_rd[EW-FLOAT_WIDTH-1 -: FLOAT_WIDTH];
  assign head_tag  = fifo_rd[TAG_WIDTH-1:0];

  // The head is consumed exactly when the FSM loads it into add_a/add_b below.
  assign fifo_pop = ~fifo_empty &
                    ((state == S_IDLE) | ((state == S_RESP) & res_ready));

  float_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef FLOAT_ADD_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      add_req   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      tag_q     <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_tag   <= '0;
`ifdef FLOAT_ADD_ISSUE_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            add_a   <= head_a;
            add_b   <= head_b;
            tag_q   <= head_tag;
            add_req <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          add_req <= 1'b0;
          state   <= S_WAIT;
`ifdef FLOAT_ADD_ISSUE_TIMEOUT_EN
          wait_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (add_ack) begin
            res_out   <= add_out;
            res_tag   <= tag_q;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end
`ifdef FLOAT_ADD_ISSUE_TIMEOUT_EN
          // Terminal count reached with no ack: abandon the op; a late ack lands outside WAIT.
          else if (wait_cnt == '0) begin
            res_out     <= FLOAT_QNAN;
            res_tag     <= tag_q;
            res_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!fifo_empty) begin
              add_a   <= head_a;
              add_b   <= head_b;
              tag_q   <= head_tag;
              add_req <= 1'b1;
              state   <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_issue.sv
// Directed bench for float_add_issue with a 4-cycle pipeline stand-in whose sums
// come from a hand-computed lookup table; covers the optional watchdog when enabled.
module tb_float_add_issue;

  localparam logic [31:0] F_1_0   = 32'h3f800000;
  localparam logic [31:0] F_2_0   = 32'h40000000;
  localparam logic [31:0] F_3_0   = 32'h40400000;
  localparam logic [31:0] F_5_0   = 32'h40a00000;
  localparam logic [31:0] F_M5_1  = 32'hc0a33333;
  localparam logic [31:0] F_M3_2  = 32'hc04ccccd;
  localparam logic [31:0] F_M8_3  = 32'hc104cccd;
  localparam logic [31:0] F_1_5   = 32'h3fc00000;
  localparam logic [31:0] F_M1_25 = 32'hbfa00000;
  localparam logic [31:0] F_0_25  = 32'h3e800000;
  localparam logic [31:0] F_M1_5  = 32'hbfc00000;
  localparam logic [31:0] F_0_0   = 32'h00000000;
  localparam logic [31:0] F_2000  = 32'h44fa0000;
  localparam logic [31:0] F_300   = 32'h43960000;
  localparam logic [31:0] F_2300  = 32'h450fc000;
  localparam logic [31:0] F_QNAN  = 32'h7fc00000;
  localparam logic [31:0] F_SPUR  = 32'h12345678;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        add_req;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ack;
  logic [31:0] add_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_out;
  logic [3:0]  res_tag;
  logic [2:0]  count;
  logic        timeout_err;

  logic [3:0]  pipe_sr;
  logic        stub_off;
  logic        spur_ack;

  int n_pass  = 0;
  int n_total = 0;

  float_add_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .add_req     (add_req),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_ack     (add_ack),
    .add_out     (add_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_out     (res_out),
    .res_tag     (res_tag),
    .count       (count),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fadd_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {F_1_0,  F_1_0  }: return F_2_0;
      {F_2_0,  F_3_0  }: return F_5_0;
      {F_M5_1, F_M3_2 }: return F_M8_3;
      {F_1_5,  F_M1_25}: return F_0_25;
      {F_1_5,  F_M1_5 }: return F_0_0;
      {F_2000, F_300  }: return F_2300;
      {F_1_0,  F_2_0  }: return F_3_0;
      default:           return 32'hdeadbeef;
    endcase
  endfunction

  // Pipeline stand-in: ack four cycles after the req pulse, sum from the table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_sr <= '0;
    else      pipe_sr <= {pipe_sr[2:0], add_req & ~stub_off};
  end
  assign add_ack = pipe_sr[3] | spur_ack;
  assign add_out = spur_ack ? F_SPUR : fadd_lut(add_a, add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    res_ready = 1'b0; stub_off = 1'b0; spur_ack = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({res_valid, add_req, timeout_err} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {res_valid, add_req, timeout_err});
    else n_pass++;
    n_total++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if ({res_out, res_tag, add_a, add_b} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h want zeros", res_out, res_tag, add_a, add_b);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat = 0;
    int nreq = 0;
    push(F_1_0, F_1_0, 4'd3);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (add_req) nreq++;
      if (res_valid) begin lat = c; break; end
    end
    n_total++;
    if (lat != 6) $display("FAIL single_latency: got %0d edges want 6", lat); else n_pass++;
    n_total++;
    if (nreq != 1) $display("FAIL single_req_pulse: got %0d cycles want 1", nreq); else n_pass++;
    n_total++;
    if (res_out !== F_2_0) $display("FAIL single_sum: got %h want %h", res_out, F_2_0); else n_pass++;
    n_total++;
    if (res_tag !== 4'd3) $display("FAIL single_tag: got %0d want 3", res_tag); else n_pass++;
    repeat (3) tick();
    n_total++;
    if ({res_valid, res_out, res_tag} !== {1'b1, F_2_0, 4'd3})
      $display("FAIL single_hold: got %b/%h/%0d want 1/%h/3", res_valid, res_out, res_tag, F_2_0);
    else n_pass++;
  endtask

  // Result of the single op is still pending, so the FIFO fills to DEPTH.
  task automatic test_burst();
    logic [31:0] exp_out [5];
    logic [3:0]  exp_tag [5];
    int idx = 0;
    exp_out[0] = F_2_0;  exp_tag[0] = 4'd3;
    exp_out[1] = F_5_0;  exp_tag[1] = 4'd0;
    exp_out[2] = F_M8_3; exp_tag[2] = 4'd1;
    exp_out[3] = F_0_25; exp_tag[3] = 4'd2;
    exp_out[4] = F_0_0;  exp_tag[4] = 4'd3;
    push(F_2_0,  F_3_0,   4'd0);
    push(F_M5_1, F_M3_2,  4'd1);
    push(F_1_5,  F_M1_25, 4'd2);
    push(F_1_5,  F_M1_5,  4'd3);
    n_total++;
    if (count !== 3'd4) $display("FAIL burst_full_count: got %0d want 4", count); else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL burst_full_in_ready: got %b want 0", in_ready); else n_pass++;
    push(F_1_0, F_2_0, 4'd9);
    n_total++;
    if (count !== 3'd4) $display("FAIL burst_push_refused: count %0d want 4", count); else n_pass++;
    n_total++;
    if (res_out !== F_2_0) $display("FAIL burst_res_held: got %h want %h", res_out, F_2_0); else n_pass++;
    res_ready = 1'b1;
    for (int c = 0; c < 200 && idx < 5; c++) begin
      if (res_valid) begin
        n_total++;
        if (res_out !== exp_out[idx] || res_tag !== exp_tag[idx])
          $display("FAIL burst_result_%0d: got %h tag %0d want %h tag %0d",
                   idx, res_out, res_tag, exp_out[idx], exp_tag[idx]);
        else n_pass++;
        idx++;
      end
      tick();
    end
    res_ready = 1'b0;
    n_total++;
    if (idx != 5) $display("FAIL burst_result_count: got %0d want 5", idx); else n_pass++;
    repeat (10) tick();
    n_total++;
    if ({res_valid, count} !== {1'b0, 3'd0})
      $display("FAIL burst_drained: res_valid %b count %0d want 0/0", res_valid, count);
    else n_pass++;
  endtask

  task automatic test_spurious();
    bit seen = 0;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({res_valid, add_req} !== 2'b00)
      $display("FAIL spur_idle: res_valid %b add_req %b want 0/0", res_valid, add_req);
    else n_pass++;
    push(F_1_5, F_M1_25, 4'd5);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (res_valid) begin seen = 1; break; end
    end
    n_total++;
    if (!seen) $display("FAIL spur_op_result: res_valid %b want 1 within 30 cycles", res_valid); else n_pass++;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    tick();
    n_total++;
    if ({res_valid, res_out, res_tag} !== {1'b1, F_0_25, 4'd5})
      $display("FAIL spur_resp: got %b/%h/%0d want 1/%h/5", res_valid, res_out, res_tag, F_0_25);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    repeat (8) tick();
    n_total++;
    if ({res_valid, count} !== {1'b0, 3'd0})
      $display("FAIL spur_no_extra: res_valid %b count %0d want 0/0", res_valid, count);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    int lat = 0;
    push(F_1_0, F_1_0, 4'd1);
    push(F_2_0, F_3_0, 4'd2);
    tick();
    n_total++;
    if ({count, add_req} !== {3'd1, 1'b0})
      $display("FAIL rstw_pre: count %0d add_req %b want 1/0", count, add_req);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({res_valid, add_req, timeout_err, count} !== 6'd0)
      $display("FAIL rstw_async: got %b/%b/%b/%0d want all 0", res_valid, add_req, timeout_err, count);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    repeat (10) tick();
    n_total++;
    if ({res_valid, count} !== {1'b0, 3'd0})
      $display("FAIL rstw_discard: res_valid %b count %0d want 0/0", res_valid, count);
    else n_pass++;
    push(F_2000, F_300, 4'd6);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (res_valid) begin lat = c; break; end
    end
    n_total++;
    if ({res_out, res_tag} !== {F_2300, 4'd6} || lat != 6)
      $display("FAIL rstw_after: got %h tag %0d lat %0d want %h tag 6 lat 6", res_out, res_tag, lat, F_2300);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef FLOAT_ADD_ISSUE_TIMEOUT_EN
    int lat = 0;
    stub_off = 1'b1;
    push(F_1_0, F_1_0, 4'd2);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (res_valid) begin lat = c; break; end
    end
    n_total++;
    if (lat != 18) $display("FAIL tmo_latency: got %0d edges want 18", lat); else n_pass++;
    n_total++;
    if ({res_out, res_tag, timeout_err} !== {F_QNAN, 4'd2, 1'b1})
      $display("FAIL tmo_result: got %h tag %0d err %b want %h tag 2 err 1", res_out, res_tag, timeout_err, F_QNAN);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    stub_off = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({res_valid, timeout_err} !== 2'b01)
      $display("FAIL tmo_sticky: res_valid %b err %b want 0/1", res_valid, timeout_err);
    else n_pass++;
`else
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL tmo_disabled: err %b want 0", timeout_err); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_spurious();
    test_reset_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
